// File: rtl/prog_loader.sv
// Boot loader: accepts a framed program image (MAGIC, BASE, LEN, payload, CHK) over a
// byte valid/ready stream, writes it to RAM and releases the CPU once the checksum passes.
module prog_loader #(
  parameter logic [7:0] MAGIC   = 8'hA5,
  parameter int         TIMEOUT = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_reset,
  output logic       done,
  output logic       error,
  output logic [2:0] o_dbg_state
);

  // Handshake: a byte moves when in_valid && in_ready at posedge clock; in_ready is a
  // function of state only, and in_valid/in_data must stay stable until the transfer.

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BASE  = 3'd1,
    S_LEN   = 3'd2,
    S_LOAD  = 3'd3,
    S_CHECK = 3'd4,
    S_RUN   = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t          r_state,     w_state_n;
  logic [7:0]      r_ptr,       w_ptr_n;
  logic [8:0]      r_count,     w_count_n;
  logic [7:0]      r_sum,       w_sum_n;
  logic [TW-1:0]   r_timer,     w_timer_n;
  logic            r_mem_we,    w_mem_we_n;
  logic [7:0]      r_mem_addr,  w_mem_addr_n;
  logic [7:0]      r_mem_wdata, w_mem_wdata_n;

  logic            w_accept;
  logic            w_in_frame;
  logic [7:0]      w_sum_add;

  assign in_ready    = (r_state != S_RUN);
  assign w_accept    = in_valid && in_ready;
  assign w_sum_add   = r_sum + in_data;
  assign w_in_frame  = (r_state == S_BASE) || (r_state == S_LEN) ||
                       (r_state == S_LOAD) || (r_state == S_CHECK);

  assign done        = (r_state == S_RUN);
  assign error       = (r_state == S_ERROR);
  assign cpu_reset   = (r_state != S_RUN);
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign o_dbg_state = r_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= 8'd0;
      r_count     <= 9'd0;
      r_sum       <= 8'd0;
      r_timer     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 8'd0;
      r_mem_wdata <= 8'd0;
    end else begin
      r_state     <= w_state_n;
      r_ptr       <= w_ptr_n;
      r_count     <= w_count_n;
      r_sum       <= w_sum_n;
      r_timer     <= w_timer_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wdata <= w_mem_wdata_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_ptr_n       = r_ptr;
    w_count_n     = r_count;
    w_sum_n       = r_sum;
    w_timer_n     = '0;
    w_mem_we_n    = 1'b0;
    w_mem_addr_n  = r_mem_addr;
    w_mem_wdata_n = r_mem_wdata;

    // An accept in the expiring cycle wins over the timeout.
    if (w_in_frame && !w_accept) begin
      if (r_timer == TIMER_LAST) begin
        w_state_n = S_ERROR;
      end else begin
        w_timer_n = r_timer + TW'(1);
      end
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept && (in_data == MAGIC)) begin
          w_state_n = S_BASE;
        end
      end
      S_BASE: begin
        if (w_accept) begin
          w_ptr_n   = in_data;
          w_sum_n   = in_data;
          w_state_n = S_LEN;
        end
      end
      S_LEN: begin
        if (w_accept) begin
          w_count_n = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          w_sum_n   = w_sum_add;
          w_state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_mem_we_n    = 1'b1;
          w_mem_addr_n  = r_ptr;
          w_mem_wdata_n = in_data;
          w_ptr_n       = r_ptr + 8'd1;
          w_sum_n       = w_sum_add;
          w_count_n     = r_count - 9'd1;
          if (r_count == 9'd1) begin
            w_state_n = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (w_accept) begin
          w_sum_n   = w_sum_add;
          w_state_n = (w_sum_add == 8'd0) ? S_RUN : S_ERROR;
        end
      end
      S_RUN: begin
        w_state_n = S_RUN;
      end
      S_ERROR: begin
        if (w_accept && (in_data == MAGIC)) begin
          w_state_n = S_BASE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  a_write_follows_load: assert property (@(posedge clock) disable iff (reset)
    r_mem_we |-> ($past(r_state) == S_LOAD));

  a_run_is_terminal: assert property (@(posedge clock) disable iff (reset)
    (r_state == S_RUN) |=> (r_state == S_RUN));

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed frames, write scoreboard checked by a negedge monitor,
// plus status checks for done/error/cpu_reset/state at the frame boundaries.
module tb_prog_loader;

  localparam int TIMEOUT = 8;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BASE  = 3'd1;
  localparam logic [2:0] ST_LEN   = 3'd2;
  localparam logic [2:0] ST_LOAD  = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_RUN   = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_reset;
  logic       done;
  logic       error;
  logic [2:0] dbg_state;

  logic [7:0]  ram [256];
  logic [15:0] exp_q[$];
  logic [7:0]  pay_q[$];
  logic [15:0] mon_exp;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_writes = 0;

  prog_loader #(.MAGIC(8'hA5), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error),
    .o_dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  task automatic tally(input string name, input bit ok, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tally(name, act === exp, int'(act), int'(exp));
  endtask

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    tally(name, act === exp, int'(act), int'(exp));
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tally(name, act === exp, int'(act), int'(exp));
  endtask

  task automatic check_status(input string tag, input logic rdy, input logic dn,
                              input logic er, input logic crst, input logic [2:0] st);
    check1({tag, "_in_ready"}, in_ready, rdy);
    check1({tag, "_done"}, done, dn);
    check1({tag, "_error"}, error, er);
    check1({tag, "_cpu_reset"}, cpu_reset, crst);
    check3({tag, "_state"}, dbg_state, st);
  endtask

  always @(negedge clock) begin
    if (mem_we) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        tally("unexpected_write", 1'b0, int'({mem_addr, mem_wdata}), 0);
      end else begin
        mon_exp = exp_q.pop_front();
        tally("write_addr_data", {mem_addr, mem_wdata} === mon_exp,
              int'({mem_addr, mem_wdata}), int'(mon_exp));
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after posedge
  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!in_ready) tally("ready_wait_timeout", 1'b0, 0, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Frame from pay_q; gap inserts one idle cycle after every payload byte.
  task automatic send_frame(input logic [7:0] base, input logic [7:0] chk, input bit gap);
    send_byte(8'hA5);
    send_byte(base);
    send_byte(8'(pay_q.size()));
    for (int i = 0; i < pay_q.size(); i++) begin
      exp_q.push_back({8'(base + 8'(i)), pay_q[i]});
      send_byte(pay_q[i]);
      if (gap) idle(1);
    end
    send_byte(chk);
  endtask

  initial begin
    int wr0;
    int bad;

    // Reset state
    do_reset();
    check_status("rst", 1'b1, 1'b0, 1'b0, 1'b1, ST_IDLE);
    check1("rst_mem_we", mem_we, 1'b0);
    check8("rst_mem_addr", mem_addr, 8'h00);
    check8("rst_mem_wdata", mem_wdata, 8'h00);

    // Basic load: 10+03+01+02+03 = 0x19, chk E7
    pay_q.delete();
    pay_q.push_back(8'h01); pay_q.push_back(8'h02); pay_q.push_back(8'h03);
    send_frame(8'h10, 8'hE7, 1'b0);
    check_status("basic", 1'b0, 1'b1, 1'b0, 1'b0, ST_RUN);
    idle(3);
    check_status("basic_hold", 1'b0, 1'b1, 1'b0, 1'b0, ST_RUN);
    check8("basic_ram10", ram[8'h10], 8'h01);
    check8("basic_ram12", ram[8'h12], 8'h03);

    // Address wrap: FE+04+AA+BB+CC+DD = 0x410 -> chk F0
    do_reset();
    pay_q.delete();
    pay_q.push_back(8'hAA); pay_q.push_back(8'hBB);
    pay_q.push_back(8'hCC); pay_q.push_back(8'hDD);
    send_frame(8'hFE, 8'hF0, 1'b0);
    check_status("wrap", 1'b0, 1'b1, 1'b0, 1'b0, ST_RUN);
    check8("wrap_ram00", ram[8'h00], 8'hCC);
    check8("wrap_ram01", ram[8'h01], 8'hDD);

    // Bad checksum (10+01+55+00 = 0x66), then retry 20+01+77+68 = 0x100
    do_reset();
    pay_q.delete();
    pay_q.push_back(8'h55);
    send_frame(8'h10, 8'h00, 1'b0);
    check_status("badchk", 1'b1, 1'b0, 1'b1, 1'b1, ST_ERROR);
    check8("badchk_ram10", ram[8'h10], 8'h55);
    send_byte(8'h3C);
    check_status("err_noise", 1'b1, 1'b0, 1'b1, 1'b1, ST_ERROR);
    pay_q.delete();
    pay_q.push_back(8'h77);
    send_byte(8'hA5);
    check_status("retry_magic", 1'b1, 1'b0, 1'b0, 1'b1, ST_BASE);
    send_byte(8'h20);
    send_byte(8'h01);
    exp_q.push_back({8'h20, 8'h77});
    send_byte(8'h77);
    check3("retry_check_state", dbg_state, ST_CHECK);
    send_byte(8'h68);
    check_status("retry", 1'b0, 1'b1, 1'b0, 1'b0, ST_RUN);

    // Noise then timeout boundary
    do_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    check_status("noise", 1'b1, 1'b0, 1'b0, 1'b1, ST_IDLE);
    send_byte(8'hA5);
    send_byte(8'h10);
    idle(TIMEOUT - 1);
    check3("to_len_hold", dbg_state, ST_LEN);
    send_byte(8'h01);
    check_status("to_late_accept", 1'b1, 1'b0, 1'b0, 1'b1, ST_LOAD);
    idle(TIMEOUT - 1);
    check3("to_load_hold", dbg_state, ST_LOAD);
    idle(1);
    check_status("timeout", 1'b1, 1'b0, 1'b1, 1'b1, ST_ERROR);

    // Throttled LEN=0 image 00..FF at base 00: sum 0x7F80 -> chk 80
    do_reset();
    pay_q.delete();
    for (int i = 0; i < 256; i++) pay_q.push_back(8'(i));
    wr0 = n_writes;
    send_frame(8'h00, 8'h80, 1'b1);
    check_status("len0", 1'b0, 1'b1, 1'b0, 1'b0, ST_RUN);
    tally("len0_write_count", (n_writes - wr0) == 256, n_writes - wr0, 256);
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== 8'(i)) bad++;
    tally("len0_ram_image_bad_bytes", bad == 0, bad, 0);

    // Reset mid-LOAD after 2 of 3 payload bytes
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h30);
    send_byte(8'h03);
    exp_q.push_back({8'h30, 8'h11});
    send_byte(8'h11);
    exp_q.push_back({8'h31, 8'h22});
    send_byte(8'h22);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_status("midrst", 1'b1, 1'b0, 1'b0, 1'b1, ST_IDLE);
    check1("midrst_mem_we", mem_we, 1'b0);
    check8("midrst_mem_addr", mem_addr, 8'h00);
    check8("midrst_mem_wdata", mem_wdata, 8'h00);
    check8("midrst_ram30", ram[8'h30], 8'h11);
    check8("midrst_ram31", ram[8'h31], 8'h22);
    reset = 1'b0;
    idle(2);

    tally("exp_q_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
